// File: rtl/axis_rr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_pkt_arbiter
//
// Packet-level round-robin arbiter that merges NUM_PORTS AXI4-Stream ingress
// streams onto one egress stream. A port is granted for a whole packet and
// keeps the grant until its tlast beat is accepted, so packets never
// interleave. Arbitration takes one idle cycle per packet. The egress side is
// a two-entry (main + skid) register slice, so every m_axis signal is a flop
// and the stream sustains one beat per cycle.
//
// Build option:
//   ARB_PKT_COUNT_EN  when defined, builds one free-running 32-bit packet
//                     counter per port (counts accepted tlast beats). When
//                     undefined, pkt_count is tied to zero.
//
// Ports:
//   axis_aclk, axis_resetn        clock, asynchronous active-low reset
//   s_axis_t{data,keep,user}      per-port ingress payload, port i in slice i
//   s_axis_t{valid,ready,last}    per-port handshake (at most one ready high)
//   m_axis_t{data,keep,user,last} arbitrated egress payload (registered)
//   m_axis_t{valid,ready}         egress handshake
//   grant_idx                     currently / most recently granted port
//   busy                          high while a packet is in progress
//   pkt_count                     per-port packet counters, 32 bits each
// -----------------------------------------------------------------------------
module axis_rr_pkt_arbiter #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int NUM_PORTS        = 4,
    parameter int PORT_IDX_W       = 3
) (
    input  logic                                   axis_aclk,
    input  logic                                   axis_resetn,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                   s_axis_tready,
    input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic [PORT_IDX_W-1:0]                  grant_idx,
    output logic                                   busy,
    output logic [NUM_PORTS*32-1:0]                pkt_count
);
    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int PAD_N  = 2 ** PORT_IDX_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                      state, state_nxt;
    logic [PORT_IDX_W-1:0]       rr_ptr, rr_ptr_nxt, grant_nxt, sel_idx;
    logic [PORT_IDX_W:0]         cand;
    logic                        sel_found;
    logic [PAD_N-1:0]            valid_pad;

    logic                        in_valid_p0, in_last_p0, accept_p0;
    logic [AXIS_DATA_WIDTH-1:0]  in_data_p0;
    logic [KEEP_W-1:0]           in_keep_p0;
    logic [AXIS_TUSER_WIDTH-1:0] in_user_p0;

    logic                        skid_vld_p1, skid_last_p1;
    logic [AXIS_DATA_WIDTH-1:0]  skid_data_p1;
    logic [KEEP_W-1:0]           skid_keep_p1;
    logic [AXIS_TUSER_WIDTH-1:0] skid_user_p1;

    // Zero-extending the valid vector lets a PORT_IDX_W-bit index address it
    // directly; the padding bits are never set, so ports >= NUM_PORTS never win.
    assign valid_pad = PAD_N'(s_axis_tvalid);

    // Round-robin search: walk offsets from the highest down so the lowest
    // offset from rr_ptr is the one left in sel_idx.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (PORT_IDX_W+1)'(k);
            if (cand >= (PORT_IDX_W+1)'(NUM_PORTS))
                cand = cand - (PORT_IDX_W+1)'(NUM_PORTS);
            if (valid_pad[cand[PORT_IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PORT_IDX_W-1:0];
            end
        end
    end

    // Stage p0: payload of the granted port.
    always_comb begin
        in_valid_p0   = 1'b0;
        in_last_p0    = 1'b0;
        in_data_p0    = '0;
        in_keep_p0    = '0;
        in_user_p0    = '0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == PORT_IDX_W'(i)) begin
                in_valid_p0      = s_axis_tvalid[i];
                in_last_p0       = s_axis_tlast[i];
                in_data_p0       = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                in_keep_p0       = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                in_user_p0       = s_axis_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
                s_axis_tready[i] = (state == BUSY) && !skid_vld_p1;
            end
        end
    end

    assign accept_p0 = (state == BUSY) && in_valid_p0 && !skid_vld_p1;
    assign busy      = (state == BUSY);

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_idx;
        rr_ptr_nxt = rr_ptr;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = BUSY;
                    grant_nxt = sel_idx;
                end
            end
            BUSY: begin
                if (accept_p0 && in_last_p0) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_idx == PORT_IDX_W'(NUM_PORTS - 1)) ? '0
                                                                          : grant_idx + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_idx <= grant_nxt;
        end
    end

    // Stage p1: output register slice. The skid entry only fills when the main
    // entry is stalled, and while it is full the input side is held off, so a
    // full skid always drains into main on the next downstream ready.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            skid_vld_p1   <= 1'b0;
            skid_last_p1  <= 1'b0;
            skid_data_p1  <= '0;
            skid_keep_p1  <= '0;
            skid_user_p1  <= '0;
        end else if (skid_vld_p1) begin
            if (m_axis_tready) begin
                m_axis_tlast <= skid_last_p1;
                m_axis_tdata <= skid_data_p1;
                m_axis_tkeep <= skid_keep_p1;
                m_axis_tuser <= skid_user_p1;
                skid_vld_p1  <= 1'b0;
            end
        end else if (accept_p0) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= in_last_p0;
                m_axis_tdata  <= in_data_p0;
                m_axis_tkeep  <= in_keep_p0;
                m_axis_tuser  <= in_user_p0;
            end else begin
                skid_vld_p1  <= 1'b1;
                skid_last_p1 <= in_last_p0;
                skid_data_p1 <= in_data_p0;
                skid_keep_p1 <= in_keep_p0;
                skid_user_p1 <= in_user_p0;
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef ARB_PKT_COUNT_EN
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_count <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept_p0 && in_last_p0 && (grant_idx == PORT_IDX_W'(i)))
                    pkt_count[i*32 +: 32] <= pkt_count[i*32 +: 32] + 32'd1;
            end
        end
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for axis_rr_pkt_arbiter. Per-port packet queues feed the DUT; a
// packet-level round-robin model predicts the egress beat order when packets
// are launched, and a monitor on the egress side pops and compares.
// -----------------------------------------------------------------------------
module tb_axis_rr_pkt_arbiter;
    localparam int DW = 64;
    localparam int UW = 16;
    localparam int NP = 4;
    localparam int IW = 3;
    localparam int KW = DW / 8;
    localparam int DRAIN_LIMIT = 3000;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            gap;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [NP-1:0]     s_tlast;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [IW-1:0]     grant_idx;
    logic              busy;
    logic [NP*32-1:0]  pkt_count;

    axis_rr_pkt_arbiter #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_TUSER_WIDTH(UW),
        .NUM_PORTS       (NP),
        .PORT_IDX_W      (IW)
    ) dut (
        .axis_aclk    (clk),
        .axis_resetn  (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Driver-side queues (what each port still has to send) and the
    // staging area used to build a scenario before it is launched.
    beat_t pq[NP][$];
    beat_t stg_beats[NP][$];
    int    stg_len[NP][$];
    beat_t exp_q[$];
    int    gap_cnt[NP];
    int    exp_pkts[NP];
    int    mptr = 0;
    logic [NP-1:0] acc = '0;

    int  mready_mode = 0;
    int  pat_idx = 0;
    int  out_beats = 0;
    int  first_out_cyc = -1;
    int  last_out_cyc = -1;
    int  occ = 0;
    bit  prev_stall = 0;
    logic [127:0] prev_out = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    function automatic logic [127:0] pack(input beat_t b);
        return {39'b0, b.data, b.keep, b.user, b.last};
    endfunction

    function automatic bit pending();
        for (int p = 0; p < NP; p++) if (pq[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Ingress driver: advances a port on the handshake recorded at the
    // preceding negedge, honours mid-packet gaps, and drives m_tready.
    always @(posedge clk) begin
        beat_t tmp;
        #1;
        for (int p = 0; p < NP; p++) begin
            if (!rst_n) begin
                s_tvalid[p] = 1'b0;
            end else begin
                if (acc[p] && pq[p].size() > 0) begin
                    tmp = pq[p].pop_front();
                    if (pq[p].size() > 0) gap_cnt[p] = pq[p][0].gap;
                end
                if (pq[p].size() > 0 && gap_cnt[p] == 0) begin
                    s_tvalid[p]          = 1'b1;
                    s_tdata[p*DW +: DW]  = pq[p][0].data;
                    s_tkeep[p*KW +: KW]  = pq[p][0].keep;
                    s_tuser[p*UW +: UW]  = pq[p][0].user;
                    s_tlast[p]           = pq[p][0].last;
                end else begin
                    s_tvalid[p] = 1'b0;
                    if (gap_cnt[p] > 0) gap_cnt[p]--;
                end
            end
        end
        case (mready_mode)
            1:       m_tready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            2:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b1;
        endcase
        pat_idx++;
    end

    // Egress monitor and protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t e;
        logic [NP-1:0] mask;
        if (!rst_n) begin
            acc        = '0;
            occ        = 0;
            prev_stall = 0;
        end else begin
            acc = s_tvalid & s_tready;
            check("tready_onehot", {126'b0, ($countones(s_tready) <= 1), (busy || s_tready == '0)}, 128'd3);
            for (int p = 0; p < NP; p++) begin
                if (gap_cnt[p] > 0) begin
                    mask = '1;
                    mask[p] = 1'b0;
                    check("grant_held_in_gap", {busy, grant_idx, s_tready & mask}, {1'b1, IW'(p), NP'(0)});
                end
            end
            if (prev_stall)
                check("stall_stable", {m_tvalid, pack('{m_tdata, m_tkeep, m_tuser, m_tlast, 0})},
                      {1'b1, prev_out});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", pack('{m_tdata, m_tkeep, m_tuser, m_tlast, 0}), 128'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", pack('{m_tdata, m_tkeep, m_tuser, m_tlast, 0}), pack(e));
                end
                out_beats++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
            end
            occ = occ + (|acc ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
            check("slice_occupancy", {127'b0, (occ <= 2 && occ >= 0)}, 128'd1);
            prev_stall = m_tvalid && !m_tready;
            prev_out   = pack('{m_tdata, m_tkeep, m_tuser, m_tlast, 0});
        end
    end

    task automatic add_pkt(input int p, input int len, input int gap_beat, input int gap_len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = KW'($urandom);
            b.user = UW'($urandom);
            b.last = (i == len - 1);
            b.gap  = (i == gap_beat && i > 0) ? gap_len : 0;
            stg_beats[p].push_back(b);
        end
        stg_len[p].push_back(len);
    endtask

    // Packet-level reference: every staged port requests at each arbitration,
    // so the order is a plain round-robin walk over ports with packets left.
    task automatic launch();
        int rem[NP];
        int total = 0;
        int p, len;
        beat_t b;
        for (int i = 0; i < NP; i++) begin
            rem[i] = stg_len[i].size();
            total += rem[i];
        end
        while (total > 0) begin
            p = mptr;
            for (int k = 0; k < NP; k++) begin
                p = (mptr + k) % NP;
                if (rem[p] > 0) break;
            end
            len = stg_len[p].pop_front();
            for (int i = 0; i < len; i++) begin
                b = stg_beats[p].pop_front();
                exp_q.push_back(b);
                pq[p].push_back(b);
            end
            rem[p]--;
            total--;
            exp_pkts[p]++;
            mptr = (p + 1) % NP;
        end
    endtask

    task automatic flush();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            stg_beats[p].delete();
            stg_len[p].delete();
            gap_cnt[p]  = 0;
            exp_pkts[p] = 0;
        end
        mptr = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || pending()) && n < DRAIN_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({"drain_", name}, {127'b0, (n < DRAIN_LIMIT)}, 128'd1);
        if (n >= DRAIN_LIMIT) begin
            rst_n = 1'b0;
            flush();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, base, lcyc, exp_cnt;
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            gap_cnt[p]  = 0;
            exp_pkts[p] = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_payload", {m_tdata, m_tkeep, m_tuser}, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy_grant", {busy, grant_idx}, 0);
        check("rst_pkt_count", pkt_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 3-beat packet from port 2
        first_out_cyc = -1;
        add_pkt(2, 3, 0, 0);
        lcyc = cyc;
        launch();
        drain("single");
        check("first_beat_latency", 128'(first_out_cyc - (lcyc + 1)), 2);
        check("grant_idx_port2", grant_idx, 2);
        check("idle_after_single", busy, 0);

        // All ports, two 2-beat packets each; one bubble between packets
        first_out_cyc = -1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 2, 0, 0);
        launch();
        drain("all_ports");
        check("bubble_span", 128'(last_out_cyc - first_out_cyc), 3 * 2 * NP - 2);

        // Granted port stalls mid-packet while port 0 waits
        add_pkt(0, 1, 0, 0);
        launch();
        drain("move_ptr");
        add_pkt(1, 4, 2, 5);
        add_pkt(0, 2, 0, 0);
        launch();
        drain("gap");

        // Downstream back-pressure 1,0,0,1 during a 10-beat packet
        mready_mode = 1;
        add_pkt(0, 10, 0, 0);
        launch();
        drain("stall");

        // Randomized traffic with gaps and random back-pressure
        mready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < NP; p++) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    base = $urandom_range(1, 6);
                    add_pkt(p, base, $urandom_range(1, 6), $urandom_range(0, 3));
                end
            end
            launch();
            drain("random");
        end
        mready_mode = 0;

        // Asynchronous reset in the middle of a 6-beat packet
        add_pkt(1, 6, 0, 0);
        base = out_beats;
        launch();
        n = 0;
        while (out_beats < base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reset_wait_beat3", {127'b0, (n < 200)}, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_m_tvalid", m_tvalid, 0);
        check("async_rst_s_tready", s_tready, 0);
        check("async_rst_busy", busy, 0);
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        add_pkt(1, 2, 0, 0);
        add_pkt(0, 3, 0, 0);
        launch();
        drain("after_reset");

        // Packet counters: 5 from port 3, 2 from port 0
        do_reset();
        for (int k = 0; k < 5; k++) add_pkt(3, $urandom_range(1, 4), 0, 0);
        for (int k = 0; k < 2; k++) add_pkt(0, $urandom_range(1, 4), 0, 0);
        launch();
        drain("counters");
        for (int p = 0; p < NP; p++) begin
`ifdef ARB_PKT_COUNT_EN
            exp_cnt = exp_pkts[p];
`else
            exp_cnt = 0;
`endif
            check($sformatf("pkt_count_%0d", p), pkt_count[p*32 +: 32], exp_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_rr_pkt_arbiter.md
Name: axis_rr_pkt_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI4-Stream datapath, such as the reconfigurable_partition UDP processing block, between NUM_PORTS ingress streams.
- Grants one port per packet and holds the grant until tlast, so packets are never interleaved.
- Output passes through a full-throughput two-entry register slice, so all m_axis signals come from flops.
- Sits between the ingress MAC/FIFO streams and the partition's s_axis port.

Parameters:
- AXIS_DATA_WIDTH, 512, tdata width; tkeep width is AXIS_DATA_WIDTH/8.
- AXIS_TUSER_WIDTH, 256, tuser width; passed through unmodified.
- NUM_PORTS, 4, number of ingress ports; legal range 2..8.
- PORT_IDX_W, 3, width of the port index; must satisfy 2**PORT_IDX_W >= NUM_PORTS.

Ports:
- axis_aclk  in  1  sole clock; all logic on rising edge.
- axis_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*AXIS_DATA_WIDTH  per-port data; port i occupies slice [i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH].
- s_axis_tkeep  in  NUM_PORTS*AXIS_DATA_WIDTH/8  per-port keep.
- s_axis_tuser  in  NUM_PORTS*AXIS_TUSER_WIDTH  per-port user.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready; at most one bit high.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- m_axis_tdata/tkeep/tuser  out  AXIS_DATA_WIDTH / AXIS_DATA_WIDTH/8 / AXIS_TUSER_WIDTH  arbitrated stream.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  output last.
- grant_idx  out  PORT_IDX_W  currently or most recently granted port.
- busy  out  1  high while a packet is in progress (state BUSY).
- pkt_count  out  NUM_PORTS*32  per-port packet counters (see Optional Feature).

Behaviour:
- Reset (async assert, sync release) drives:
  - state=IDLE, rr_ptr=0, grant_idx=0, busy=0;
  - s_axis_tready=0;
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0;
  - register slice empty, pkt_count=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - All s_axis_tready are 0.
  - If any tvalid is high, select the first valid port searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ... mod NUM_PORTS).
  - Register the selection into grant_idx and go to BUSY on the next edge.
  - Arbitration costs one bubble cycle per packet.
- BUSY:
  - s_axis_tready[grant_idx] = slice_can_accept; every other ready bit is 0.
  - A beat is accepted when tvalid and tready are both high.
  - On an accepted beat with tlast=1: go to IDLE and set rr_ptr = (grant_idx+1) mod NUM_PORTS.
  - If the granted tvalid drops mid-packet, the FSM stays BUSY and holds the grant indefinitely; there is no timeout.
- Single-beat packet (tlast on the first beat): one BUSY cycle, then IDLE.
- Register slice:
  - Two entries, main plus skid.
  - slice_can_accept = skid entry empty.
  - Latency from accepted input beat to m_axis_tvalid is 1 cycle.
  - Sustains 1 beat/cycle while m_axis_tready=1.
  - When m_axis_tready=0, m_axis outputs hold stable; at most one more beat is absorbed into the skid, then tready drops.
- tdata/tkeep/tuser/tlast are copied bit-exact; tkeep is not interpreted.
- Fairness: with all ports continuously requesting, the grant order is 0,1,2,3,0,... and no port waits more than NUM_PORTS-1 packets.
- Reset mid-packet: the partial packet is discarded and the slice is cleared. Downstream sees a truncated packet with no tlast; that is acceptable.
- If grant_idx would index a port >= NUM_PORTS, the block never selects it.

Optional Feature:
- Macro: ARB_PKT_COUNT_EN.
- Defined: pkt_count[i*32 +: 32] increments by 1 on every accepted tlast beat from port i. The counters are free-running, wrap from 0xFFFFFFFF to 0, and are reset only by axis_resetn.
- Undefined: no counter flops are built; pkt_count is tied to 0 and the port stays present.

Test Plan:
- Only port 2 sends a 3-beat packet, m_axis_tready=1 -> one IDLE bubble, then 3 beats out with first m_axis_tvalid 2 cycles after port 2 tvalid; data is bit-exact, tlast on beat 3; grant_idx=2; rr_ptr becomes 3.
- All 4 ports hold 2-beat packets continuously -> output packet source order 0,1,2,3,0,1; packets never interleave; each packet is followed by exactly one idle cycle.
- Port 1 packet of 4 beats with tvalid low for 5 cycles after beat 2, while port 0 is valid -> port 0 tready stays 0; port 1 completes beats 3-4; port 0 is granted only afterwards.
- m_axis_tready toggles 1,0,0,1 repeating during a 10-beat packet -> no beat lost or duplicated; m_axis_tdata stable while tvalid=1 and tready=0; at most 1 beat accepted during each stall.
- axis_resetn pulsed low at beat 3 of a 6-beat packet -> m_axis_tvalid=0 and all s_axis_tready=0 immediately (async); after release, a new packet from port 0 is granted first.
- With ARB_PKT_COUNT_EN, send 5 packets from port 3 and 2 from port 0 -> pkt_count port 3 = 5, port 0 = 2, others 0. Without the macro -> pkt_count = 0.
